cond_flag_unit: RTL and testbench

//  Condition/flag stage directly downstream of the ALU in the single-cycle datapath.

---
 rtl/cond_pkg.sv | 17 +
 rtl/cond_check.sv | 41 ++++
 rtl/cond_flag_unit.sv | 81 ++++++++
 tb/tb_cond_flag_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - condition codes, NZCV bit positions and flag type for cond_flag_unit
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE, CS, CC, MI, PL, VS, VC,
        HI, LS, GE, LT, GT, LE, AL,
        NV = 4'hF
    } cond_e;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational evaluation of a 4-bit condition field against stored NZCV
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] i_cond,
    input  flags_t     i_flags,
    output logic       o_cond_ex
);

    logic w_n, w_z, w_c, w_v, w_ge;

    assign w_n  = i_flags[FLG_N];
    assign w_z  = i_flags[FLG_Z];
    assign w_c  = i_flags[FLG_C];
    assign w_v  = i_flags[FLG_V];
    assign w_ge = (w_n == w_v);

    always_comb begin
        o_cond_ex = 1'b0;
        case (cond_e'(i_cond))
            EQ: o_cond_ex = w_z;
            NE: o_cond_ex = ~w_z;
            CS: o_cond_ex = w_c;
            CC: o_cond_ex = ~w_c;
            MI: o_cond_ex = w_n;
            PL: o_cond_ex = ~w_n;
            VS: o_cond_ex = w_v;
            VC: o_cond_ex = ~w_v;
            HI: o_cond_ex = w_c & ~w_z;
            LS: o_cond_ex = ~w_c | w_z;
            GE: o_cond_ex = w_ge;
            LT: o_cond_ex = ~w_ge;
            GT: o_cond_ex = ~w_z & w_ge;
            LE: o_cond_ex = w_z | ~w_ge;
            AL: o_cond_ex = 1'b1;
            NV: o_cond_ex = 1'b0;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// rtl/cond_flag_unit.sv - NZCV register, condition gating of PCS/RegW/MemW; COND_OVF_COUNT_EN adds overflow counter
module cond_flag_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output flags_t     Flags
`ifdef COND_OVF_COUNT_EN
    ,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_count
`endif
);

    flags_t r_flags;
    logic   w_cond_ex;
    logic   w_wr_nz;
    logic   w_wr_cv;

    // Condition is judged on flags left by earlier instructions, not this ALU result
    cond_check u_cond_check (
        .i_cond    (Cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    assign w_wr_nz = en & w_cond_ex & FlagW[1];
    assign w_wr_cv = en & w_cond_ex & FlagW[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else begin
            if (w_wr_nz) begin
                r_flags[FLG_N] <= ALUFlags[FLG_N];
                r_flags[FLG_Z] <= ALUFlags[FLG_Z];
            end
            if (w_wr_cv) begin
                r_flags[FLG_C] <= ALUFlags[FLG_C];
                r_flags[FLG_V] <= ALUFlags[FLG_V];
            end
        end
    end

    assign CondEx   = w_cond_ex;
    assign PCSrc    = PCS & w_cond_ex;
    assign RegWrite = RegW & w_cond_ex & ~NoWrite;
    assign MemWrite = MemW & w_cond_ex;
    assign Flags    = r_flags;

`ifdef COND_OVF_COUNT_EN
    logic [CNT_W-1:0] r_ovf_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_count <= '0;
        end else if (ovf_clr) begin
            r_ovf_count <= '0;
        end else if (w_wr_cv && ALUFlags[FLG_V] && (r_ovf_count != {CNT_W{1'b1}})) begin
            r_ovf_count <= r_ovf_count + 1'b1;
        end
    end

    assign ovf_count = r_ovf_count;
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb/tb_cond_flag_unit.sv - directed self-checking bench for cond_flag_unit (COND_OVF_COUNT_EN optional)
module tb_cond_flag_unit;

`ifdef COND_OVF_COUNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, NoWrite;
    logic       PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;
`ifdef COND_OVF_COUNT_EN
    logic          ovf_clr;
    logic [CW-1:0] ovf_count;
`endif

    int tests = 0;
    int fails = 0;

    cond_flag_unit #(.CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .NoWrite  (NoWrite),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Flags    (Flags)
`ifdef COND_OVF_COUNT_EN
        ,
        .ovf_clr  (ovf_clr),
        .ovf_count(ovf_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference condition table written directly from the architectural definition
    function automatic logic golden(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic load_flags(input logic [3:0] f);
        Cond = 4'hE; FlagW = 2'b11; ALUFlags = f; en = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
`ifdef COND_OVF_COUNT_EN
        ovf_clr = 1'b0;
`endif
        #2;
        // 1. reset state
        chk("rst_flags", 32'(Flags), 32'h0);
        chk("rst_eq_condex", 32'(CondEx), 32'h0);
        Cond = 4'hE; #1;
        chk("rst_al_condex", 32'(CondEx), 32'h1);
`ifdef COND_OVF_COUNT_EN
        chk("rst_ovf_count", 32'(ovf_count), 32'h0);
`endif
        tick();
        rst_n = 1'b1;

        // 2. AL write, then EQ/NE see the new Z
        Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b0100;
        tick();
        chk("al_write_flags", 32'(Flags), 32'h4);
        Cond = 4'h0; #1;
        chk("eq_after_write", 32'(CondEx), 32'h1);
        Cond = 4'h1; #1;
        chk("ne_after_write", 32'(CondEx), 32'h0);

        // 3. failed condition masks strobes and flag write
        Cond = 4'h1; FlagW = 2'b11; ALUFlags = 4'b1011; RegW = 1'b1; PCS = 1'b1; MemW = 1'b1; #1;
        chk("fail_pcsrc", 32'(PCSrc), 32'h0);
        chk("fail_regwrite", 32'(RegWrite), 32'h0);
        chk("fail_memwrite", 32'(MemWrite), 32'h0);
        tick();
        chk("fail_flags_hold", 32'(Flags), 32'h4);
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;

        // 4. split N,Z / C,V writes
        load_flags(4'b0000);
        chk("split_clear", 32'(Flags), 32'h0);
        Cond = 4'hE; FlagW = 2'b01; ALUFlags = 4'b1111;
        tick();
        chk("split_cv_only", 32'(Flags), 32'h3);
        FlagW = 2'b10; ALUFlags = 4'b0100;
        tick();
        chk("split_nz_only", 32'(Flags), 32'h7);

        // 5. full Cond x Flags sweep with strobe gating
        PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            FlagW = 2'b00;
            for (int c = 0; c < 16; c++) begin
                logic g;
                Cond = 4'(c);
                NoWrite = 1'(c & 1);
                #1;
                g = golden(4'(c), 4'(f));
                chk($sformatf("sweep_condex_c%0d_f%0d", c, f), 32'(CondEx), 32'(g));
                chk($sformatf("sweep_pcsrc_c%0d_f%0d", c, f), 32'(PCSrc), 32'(g));
                chk($sformatf("sweep_memw_c%0d_f%0d", c, f), 32'(MemWrite), 32'(g));
                chk($sformatf("sweep_regw_c%0d_f%0d", c, f), 32'(RegWrite), 32'(g & ~NoWrite));
            end
        end
        Cond = 4'hE; NoWrite = 1'b1; #1;
        chk("nowrite_regwrite", 32'(RegWrite), 32'h0);
        NoWrite = 1'b0;

        // 6. en=0 freezes flags, strobes stay combinational
        load_flags(4'b0101);
        en = 1'b0; Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b1111; #1;
        chk("stall_condex", 32'(CondEx), 32'h1);
        chk("stall_pcsrc", 32'(PCSrc), 32'h1);
        tick();
        chk("stall_flags_hold", 32'(Flags), 32'h5);
        en = 1'b1;

`ifdef COND_OVF_COUNT_EN
        ovf_clr = 1'b1; FlagW = 2'b00;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf_count), 32'h0);
        Cond = 4'hE; FlagW = 2'b01; ALUFlags = 4'b0001;
        tick(); chk("ovf_cnt1", 32'(ovf_count), 32'h1);
        tick(); chk("ovf_cnt2", 32'(ovf_count), 32'h2);
        tick(); chk("ovf_cnt3", 32'(ovf_count), 32'h3);
        tick(); chk("ovf_saturate", 32'(ovf_count), 32'h3);
        ovf_clr = 1'b1;
        tick(); chk("ovf_clr_priority", 32'(ovf_count), 32'h0);
        ovf_clr = 1'b0;
        FlagW = 2'b10;
        tick(); chk("ovf_nz_only_no_inc", 32'(ovf_count), 32'h0);
`endif

        // asynchronous reset mid-cycle
        load_flags(4'b0101);
        #2 rst_n = 1'b0; #1;
        chk("async_rst_flags", 32'(Flags), 32'h0);
        Cond = 4'h0; #1;
        chk("async_rst_eq", 32'(CondEx), 32'h0);
        Cond = 4'h1; #1;
        chk("async_rst_ne", 32'(CondEx), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
